// File: rtl/csr_machine_trap.sv
// Machine-mode CSR file, hart privilege level and trap entry / MRET return sequencer.
// Latency: event accepted in cycle N -> CSR update plus one-cycle redirect in N+1 -> back to RUN in N+2.
// Backpressure: none; busy is high in TRAP/RET and trap, MRET and CSR requests are ignored then.
// Ports: clk, rst (synchronous, active-high); csr_* access port with combinational rdata/illegal;
//   pc, instr_retired, exc_*, mret_req, irq_* from the pipeline; priv_lvl, redirect_*, busy, irq_pending out.
// Optional: define CSR_COUNTER_INHIBIT_EN to add mcountinhibit at 0x320 (CY, IR freeze bits).
module csr_machine_trap #(
    parameter int          XLEN    = 64,
    parameter int          NUM_PMP = 4,
    parameter int unsigned HART_ID = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            csr_valid,
    input  logic [1:0]      csr_op,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_wdata,
    output logic [XLEN-1:0] csr_rdata,
    output logic            csr_illegal,
    input  logic [XLEN-1:0] pc,
    input  logic            instr_retired,
    input  logic            exc_req,
    input  logic [3:0]      exc_cause,
    input  logic [XLEN-1:0] exc_tval,
    input  logic            mret_req,
    input  logic            irq_ext,
    input  logic            irq_soft,
    input  logic            irq_timer,
    output logic [1:0]      priv_lvl,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            busy,
    output logic            irq_pending
);
    typedef enum logic [1:0] {ST_RUN, ST_TRAP, ST_RET} state_t;

    localparam logic [1:0]      MXL      = (XLEN == 64) ? 2'd2 : 2'd1;
    localparam logic [XLEN-1:0] MISA_VAL = {MXL, {(XLEN-2){1'b0}}} | XLEN'(32'h100);
    localparam logic [XLEN-1:0] MIE_MASK = XLEN'(32'h888);

    state_t          state_q, state_d;
    logic [1:0]      priv_q, priv_d;
    logic            mst_mie_q, mst_mie_d, mst_mpie_q, mst_mpie_d;
    logic [1:0]      mst_mpp_q, mst_mpp_d;
    logic [XLEN-1:0] mie_q, mie_d, mtvec_q, mtvec_d, mscratch_q, mscratch_d;
    logic [XLEN-1:0] mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d;
    logic [XLEN-1:0] pmpaddr_q [NUM_PMP];
    logic [XLEN-1:0] pmpaddr_d [NUM_PMP];
    logic [63:0]     mcycle_q, mcycle_d, minstret_q, minstret_d;
    logic [2:0]      irq_q;                     // {ext, soft, timer}, one-cycle registered lines
    logic [XLEN-1:0] pc_lat_q, pc_lat_d, tval_lat_q, tval_lat_d;
    logic [3:0]      cause_lat_q, cause_lat_d;
    logic            intr_lat_q, intr_lat_d;

    logic [XLEN-1:0] old_val, wval, mstatus_rd, mip_rd;
    logic [63:0]     wval64;
    logic            hit, eff_write, legal, accept, irq_take;
    logic [2:0]      irq_vec;
    logic [3:0]      irq_cause;
    logic            inh_cy, inh_ir;

`ifdef CSR_COUNTER_INHIBIT_EN
    logic [1:0]      inhibit_q, inhibit_d;      // {IR, CY}
    assign inh_cy = inhibit_q[0];
    assign inh_ir = inhibit_q[1];
`else
    assign inh_cy = 1'b0;
    assign inh_ir = 1'b0;
`endif

    always_comb begin
        mstatus_rd        = '0;
        mstatus_rd[3]     = mst_mie_q;
        mstatus_rd[7]     = mst_mpie_q;
        mstatus_rd[12:11] = mst_mpp_q;
        mip_rd            = '0;
        mip_rd[11]        = irq_q[2];
        mip_rd[3]         = irq_q[1];
        mip_rd[7]         = irq_q[0];
    end

    // Read mux; hit flags a mapped address for the current XLEN/build.
    always_comb begin
        hit     = 1'b1;
        old_val = '0;
        case (csr_addr)
            12'h300: old_val = mstatus_rd;
            12'h301: old_val = MISA_VAL;
            12'h304: old_val = mie_q;
            12'h305: old_val = mtvec_q;
            12'h340: old_val = mscratch_q;
            12'h341: old_val = mepc_q;
            12'h342: old_val = mcause_q;
            12'h343: old_val = mtval_q;
            12'h344: old_val = mip_rd;
            12'hF14: old_val = XLEN'(HART_ID);
            12'hB00, 12'hC00, 12'hC01: old_val = mcycle_q[XLEN-1:0];
            12'hB02, 12'hC02:          old_val = minstret_q[XLEN-1:0];
            12'hB80, 12'hC80: if (XLEN == 32) old_val = XLEN'(mcycle_q[63:32]);   else hit = 1'b0;
            12'hB82, 12'hC82: if (XLEN == 32) old_val = XLEN'(minstret_q[63:32]); else hit = 1'b0;
`ifdef CSR_COUNTER_INHIBIT_EN
            12'h320: old_val = XLEN'({inhibit_q[1], 1'b0, inhibit_q[0]});
`endif
            default: begin
                hit = 1'b0;
                for (int i = 0; i < NUM_PMP; i++) begin
                    if (csr_addr == 12'h3B0 + 12'(i)) begin
                        hit     = 1'b1;
                        old_val = pmpaddr_q[i];
                    end
                end
            end
        endcase
    end

    always_comb begin
        case (csr_op)
            2'b01:   wval = csr_wdata;
            2'b10:   wval = old_val | csr_wdata;
            2'b11:   wval = old_val & ~csr_wdata;
            default: wval = old_val;
        endcase
    end

    assign wval64      = 64'(wval);
    assign eff_write   = (csr_op == 2'b01) || (csr_op[1] && (csr_wdata != '0));
    assign legal       = hit && (priv_q >= csr_addr[9:8]) && !(eff_write && (csr_addr[11:10] == 2'b11));
    assign csr_rdata   = legal ? old_val : '0;
    assign csr_illegal = csr_valid && !legal;

    assign irq_vec     = {mie_q[11] & irq_q[2], mie_q[3] & irq_q[1], mie_q[7] & irq_q[0]};
    assign irq_pending = |irq_vec;
    assign irq_take    = irq_pending && (mst_mie_q || (priv_q != 2'd3));
    assign irq_cause   = irq_vec[2] ? 4'd11 : (irq_vec[1] ? 4'd3 : 4'd7);

    assign priv_lvl       = priv_q;
    assign busy           = (state_q != ST_RUN);
    assign redirect_valid = busy && !rst;     // a reset in TRAP/RET suppresses the pulse

    always_comb begin
        redirect_pc = '0;
        if (!rst && state_q == ST_TRAP) begin
            redirect_pc = mtvec_q & ~XLEN'(3);
            if (mtvec_q[1:0] == 2'b01 && intr_lat_q)
                redirect_pc = (mtvec_q & ~XLEN'(3)) + XLEN'({cause_lat_q, 2'b00});
        end else if (!rst && state_q == ST_RET) begin
            redirect_pc = mepc_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        priv_d      = priv_q;
        mst_mie_d   = mst_mie_q;
        mst_mpie_d  = mst_mpie_q;
        mst_mpp_d   = mst_mpp_q;
        mie_d       = mie_q;
        mtvec_d     = mtvec_q;
        mscratch_d  = mscratch_q;
        mepc_d      = mepc_q;
        mcause_d    = mcause_q;
        mtval_d     = mtval_q;
        pmpaddr_d   = pmpaddr_q;
        pc_lat_d    = pc_lat_q;
        tval_lat_d  = tval_lat_q;
        cause_lat_d = cause_lat_q;
        intr_lat_d  = intr_lat_q;
        accept      = 1'b0;
        mcycle_d    = inh_cy ? mcycle_q : mcycle_q + 64'd1;
        minstret_d  = (instr_retired && !inh_ir) ? minstret_q + 64'd1 : minstret_q;
`ifdef CSR_COUNTER_INHIBIT_EN
        inhibit_d   = inhibit_q;
`endif
        case (state_q)
            ST_RUN: begin
                if (exc_req) begin
                    accept = 1'b1; state_d = ST_TRAP; intr_lat_d = 1'b0; pc_lat_d = pc;
                    cause_lat_d = exc_cause; tval_lat_d = exc_tval;
                end else if (mret_req) begin
                    accept = 1'b1; intr_lat_d = 1'b0; pc_lat_d = pc;
                    if (priv_q == 2'd3) begin
                        state_d = ST_RET;
                    end else begin
                        // MRET below M-mode is an illegal instruction
                        state_d = ST_TRAP; cause_lat_d = 4'd2; tval_lat_d = '0;
                    end
                end else if (irq_take) begin
                    accept = 1'b1; state_d = ST_TRAP; intr_lat_d = 1'b1; pc_lat_d = pc;
                    cause_lat_d = irq_cause; tval_lat_d = '0;
                end
                if (csr_valid && legal && eff_write && !accept) begin
                    case (csr_addr)
                        12'h300: begin
                            mst_mie_d  = wval[3];
                            mst_mpie_d = wval[7];
                            if (wval[12:11] == 2'b00 || wval[12:11] == 2'b11) mst_mpp_d = wval[12:11];
                        end
                        12'h304: mie_d      = wval & MIE_MASK;
                        12'h305: mtvec_d    = {wval[XLEN-1:2], wval[1] ? 2'b00 : wval[1:0]};
                        12'h340: mscratch_d = wval;
                        12'h341: mepc_d     = wval & ~XLEN'(3);
                        12'h342: mcause_d   = wval;
                        12'h343: mtval_d    = wval;
                        12'hB00: mcycle_d   = (XLEN == 64) ? wval64 : {mcycle_q[63:32], wval64[31:0]};
                        12'hB02: minstret_d = (XLEN == 64) ? wval64 : {minstret_q[63:32], wval64[31:0]};
                        12'hB80: mcycle_d   = {wval64[31:0], mcycle_q[31:0]};
                        12'hB82: minstret_d = {wval64[31:0], minstret_q[31:0]};
`ifdef CSR_COUNTER_INHIBIT_EN
                        12'h320: inhibit_d  = {wval[2], wval[0]};
`endif
                        default: begin
                            for (int i = 0; i < NUM_PMP; i++)
                                if (csr_addr == 12'h3B0 + 12'(i)) pmpaddr_d[i] = wval;
                        end
                    endcase
                end
            end
            ST_TRAP: begin
                mepc_d     = pc_lat_q & ~XLEN'(3);
                mcause_d   = {intr_lat_q, {(XLEN-5){1'b0}}, cause_lat_q};
                mtval_d    = tval_lat_q;
                mst_mpie_d = mst_mie_q;
                mst_mie_d  = 1'b0;
                mst_mpp_d  = priv_q;
                priv_d     = 2'd3;
                state_d    = ST_RUN;
            end
            ST_RET: begin
                mst_mie_d  = mst_mpie_q;
                mst_mpie_d = 1'b1;
                priv_d     = mst_mpp_q;
                mst_mpp_d  = 2'd0;
                state_d    = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;   priv_q <= 2'd3;
            mst_mie_q <= 1'b0;   mst_mpie_q <= 1'b0; mst_mpp_q <= 2'd0;
            mie_q <= '0;         mtvec_q <= '0;      mscratch_q <= '0;
            mepc_q <= '0;        mcause_q <= '0;     mtval_q <= '0;
            for (int i = 0; i < NUM_PMP; i++) pmpaddr_q[i] <= '0;
            mcycle_q <= '0;      minstret_q <= '0;   irq_q <= '0;
            pc_lat_q <= '0;      tval_lat_q <= '0;   cause_lat_q <= '0; intr_lat_q <= 1'b0;
`ifdef CSR_COUNTER_INHIBIT_EN
            inhibit_q <= '0;
`endif
        end else begin
            state_q <= state_d;  priv_q <= priv_d;
            mst_mie_q <= mst_mie_d; mst_mpie_q <= mst_mpie_d; mst_mpp_q <= mst_mpp_d;
            mie_q <= mie_d;      mtvec_q <= mtvec_d; mscratch_q <= mscratch_d;
            mepc_q <= mepc_d;    mcause_q <= mcause_d; mtval_q <= mtval_d;
            pmpaddr_q <= pmpaddr_d;
            mcycle_q <= mcycle_d; minstret_q <= minstret_d;
            irq_q <= {irq_ext, irq_soft, irq_timer};
            pc_lat_q <= pc_lat_d; tval_lat_q <= tval_lat_d; cause_lat_q <= cause_lat_d; intr_lat_q <= intr_lat_d;
`ifdef CSR_COUNTER_INHIBIT_EN
            inhibit_q <= inhibit_d;
`endif
        end
    end
endmodule

// File: tb/tb_csr_machine_trap.sv
// Directed bench for csr_machine_trap at XLEN=64, NUM_PMP=4, HART_ID=0.
// Inputs change 2 ns after the rising edge; outputs are sampled 1 ns after that.
module tb_csr_machine_trap;
    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic            csr_valid;
    logic [1:0]      csr_op;
    logic [11:0]     csr_addr;
    logic [XLEN-1:0] csr_wdata;
    logic [XLEN-1:0] csr_rdata;
    logic            csr_illegal;
    logic [XLEN-1:0] pc;
    logic            instr_retired;
    logic            exc_req;
    logic [3:0]      exc_cause;
    logic [XLEN-1:0] exc_tval;
    logic            mret_req;
    logic            irq_ext, irq_soft, irq_timer;
    logic [1:0]      priv_lvl;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            busy;
    logic            irq_pending;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [63:0] tb_cyc;     // expected mcycle while no CSR write touches it

    csr_machine_trap #(.XLEN(XLEN), .NUM_PMP(4), .HART_ID(0)) dut (
        .clk(clk), .rst(rst),
        .csr_valid(csr_valid), .csr_op(csr_op), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
        .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
        .pc(pc), .instr_retired(instr_retired),
        .exc_req(exc_req), .exc_cause(exc_cause), .exc_tval(exc_tval), .mret_req(mret_req),
        .irq_ext(irq_ext), .irq_soft(irq_soft), .irq_timer(irq_timer),
        .priv_lvl(priv_lvl), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .busy(busy), .irq_pending(irq_pending)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) tb_cyc <= '0;
        else     tb_cyc <= tb_cyc + 64'd1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic csr(input logic [1:0] op, input logic [11:0] addr, input logic [63:0] wd);
        csr_valid = 1'b1; csr_op = op; csr_addr = addr; csr_wdata = wd;
    endtask

    task automatic rd(input string tag, input logic [11:0] addr, input logic [63:0] exp);
        csr(2'b00, addr, 64'd0);
        #1;
        chk({tag, "_legal"}, 64'(csr_illegal), 64'd0);
        chk(tag, csr_rdata, exp);
        tick();
        csr_valid = 1'b0;
    endtask

    task automatic wr(input string tag, input logic [1:0] op, input logic [11:0] addr, input logic [63:0] wd);
        csr(op, addr, wd);
        #1;
        chk({tag, "_legal"}, 64'(csr_illegal), 64'd0);
        tick();
        csr_valid = 1'b0;
    endtask

    task automatic ill(input string tag, input logic [1:0] op, input logic [11:0] addr, input logic [63:0] wd);
        csr(op, addr, wd);
        #1;
        chk(tag, 64'(csr_illegal), 64'd1);
        chk({tag, "_rdata"}, csr_rdata, 64'd0);
        csr_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; csr_valid = 1'b0; csr_op = 2'b00; csr_addr = '0; csr_wdata = '0;
        pc = '0; instr_retired = 1'b0; exc_req = 1'b0; exc_cause = '0; exc_tval = '0;
        mret_req = 1'b0; irq_ext = 1'b0; irq_soft = 1'b0; irq_timer = 1'b0;
        tick(); tick();
        #1;
        chk("rst_priv", 64'(priv_lvl), 64'd3);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_redir_vld", 64'(redirect_valid), 64'd0);
        chk("rst_redir_pc", redirect_pc, 64'd0);
        rst = 1'b0;
        tick();

        // Reset values and basic read-modify-write
        rd("misa", 12'h301, 64'h8000_0000_0000_0100);
        rd("mstatus_rst", 12'h300, 64'h0);
        csr(2'b10, 12'h300, 64'h8);
        #1;
        chk("rs_old_rdata", csr_rdata, 64'h0);
        tick();
        csr_valid = 1'b0;
        rd("mstatus_mie", 12'h300, 64'h8);

        // mtvec mode WARL, mie write mask
        wr("mtvec_w1", 2'b01, 12'h305, 64'h1003);
        rd("mtvec_mode1x", 12'h305, 64'h1000);
        wr("mtvec_w2", 2'b01, 12'h305, 64'h1001);
        rd("mtvec_vec", 12'h305, 64'h1001);
        wr("mie_all", 2'b01, 12'h304, 64'hFFFF);
        rd("mie_mask", 12'h304, 64'h888);
        wr("mie_mti", 2'b01, 12'h304, 64'h80);
        rd("mie_mti_rd", 12'h304, 64'h80);

        // Timer interrupt, vectored
        irq_timer = 1'b1; pc = 64'h2000;
        #1;
        chk("irq_sync_delay", 64'(irq_pending), 64'd0);
        tick();
        #1;
        chk("irq_pending", 64'(irq_pending), 64'd1);
        chk("irq_no_redir_yet", 64'(redirect_valid), 64'd0);
        tick();
        irq_timer = 1'b0;
        #1;
        chk("irq_redir_vld", 64'(redirect_valid), 64'd1);
        chk("irq_redir_pc", redirect_pc, 64'h101C);
        chk("irq_busy", 64'(busy), 64'd1);
        tick();
        #1;
        chk("irq_done_busy", 64'(busy), 64'd0);
        chk("irq_done_redir", 64'(redirect_valid), 64'd0);
        rd("irq_mcause", 12'h342, 64'h8000_0000_0000_0007);
        rd("irq_mepc", 12'h341, 64'h2000);
        rd("irq_mstatus", 12'h300, 64'h1880);
        rd("irq_mtval", 12'h343, 64'h0);

        // MRET back to M
        mret_req = 1'b1;
        tick();
        mret_req = 1'b0;
        #1;
        chk("mret_redir_vld", 64'(redirect_valid), 64'd1);
        chk("mret_redir_pc", redirect_pc, 64'h2000);
        chk("mret_busy", 64'(busy), 64'd1);
        tick();
        #1;
        chk("mret_done_busy", 64'(busy), 64'd0);
        chk("mret_priv", 64'(priv_lvl), 64'd3);
        rd("mret_mstatus", 12'h300, 64'h88);

        // MRET with MPP=0 drops to U
        mret_req = 1'b1;
        tick();
        mret_req = 1'b0;
        tick();
        #1;
        chk("u_priv", 64'(priv_lvl), 64'd0);
        ill("u_mstatus_rs0", 2'b10, 12'h300, 64'h0);
        csr(2'b00, 12'hC00, 64'h0);
        #1;
        chk("u_cycle_legal", 64'(csr_illegal), 64'd0);
        chk("u_cycle_val", csr_rdata, tb_cyc);
        ill("u_cycle_wr", 2'b01, 12'hC00, 64'h5);
        csr(2'b10, 12'hC00, 64'h0);
        #1;
        chk("u_cycle_rs0_legal", 64'(csr_illegal), 64'd0);
        ill("u_mcycle_rd", 2'b00, 12'hB00, 64'h0);

        // MRET from U is an illegal-instruction trap
        pc = 64'h3006; mret_req = 1'b1;
        tick();
        mret_req = 1'b0;
        #1;
        chk("umret_redir_vld", 64'(redirect_valid), 64'd1);
        chk("umret_redir_pc", redirect_pc, 64'h1000);
        tick();
        #1;
        chk("umret_priv", 64'(priv_lvl), 64'd3);
        rd("umret_mcause", 12'h342, 64'h2);
        rd("umret_mepc", 12'h341, 64'h3004);
        rd("umret_mstatus", 12'h300, 64'h80);

        // Exception beats MRET and blocks the concurrent CSR write
        pc = 64'h4000; exc_req = 1'b1; exc_cause = 4'd2; exc_tval = 64'h300; mret_req = 1'b1;
        csr(2'b01, 12'h340, 64'hDEAD);
        #1;
        chk("simul_csr_legal", 64'(csr_illegal), 64'd0);
        tick();
        exc_req = 1'b0; mret_req = 1'b0; csr_valid = 1'b0;
        #1;
        chk("simul_redir_pc", redirect_pc, 64'h1000);
        chk("simul_busy", 64'(busy), 64'd1);
        tick();
        rd("simul_mcause", 12'h342, 64'h2);
        rd("simul_mtval", 12'h343, 64'h300);
        rd("simul_mepc", 12'h341, 64'h4000);
        rd("simul_mscratch", 12'h340, 64'h0);
        rd("simul_mstatus", 12'h300, 64'h1800);

        // Interrupt priority: MEI > MSI > MTI
        wr("mie_all2", 2'b01, 12'h304, 64'h888);
        irq_ext = 1'b1; irq_soft = 1'b1; irq_timer = 1'b1;
        wr("set_mie1", 2'b10, 12'h300, 64'h8);
        csr(2'b00, 12'h344, 64'h0);
        #1;
        chk("mip_all", csr_rdata, 64'h888);
        chk("prio_pending", 64'(irq_pending), 64'd1);
        tick();
        csr_valid = 1'b0; irq_ext = 1'b0;
        #1;
        chk("mei_redir_pc", redirect_pc, 64'h102C);
        tick();
        rd("mei_mcause", 12'h342, 64'h8000_0000_0000_000B);
        wr("set_mie2", 2'b10, 12'h300, 64'h8);
        #1;
        tick();
        irq_soft = 1'b0; irq_timer = 1'b0;
        #1;
        chk("msi_redir_pc", redirect_pc, 64'h100C);
        tick();
        rd("msi_mcause", 12'h342, 64'h8000_0000_0000_0003);
        rd("msi_mstatus", 12'h300, 64'h1880);

        // MPP WARL, mip writes ignored, misc legality
        wr("mpp_w10", 2'b01, 12'h300, 64'h1000);
        rd("mpp_keep", 12'h300, 64'h1800);
        wr("mpp_w00", 2'b01, 12'h300, 64'h0);
        rd("mpp_zero", 12'h300, 64'h0);
        wr("mip_w", 2'b01, 12'h344, 64'hFFF);
        rd("mip_rd", 12'h344, 64'h0);
        rd("mhartid", 12'hF14, 64'h0);
        ill("mhartid_wr", 2'b01, 12'hF14, 64'h1);
        ill("unmapped", 2'b00, 12'h7C0, 64'h0);
        ill("pmp_oob", 2'b00, 12'h3B4, 64'h0);
        ill("mcycleh_64", 2'b00, 12'hB80, 64'h0);
        wr("pmp3_w", 2'b01, 12'h3B3, 64'h123);
        rd("pmp3_rd", 12'h3B3, 64'h123);

        // Counters: write overrides increment, carry into the upper half
        wr("mcycle_w", 2'b01, 12'hB00, 64'hFFFF_FFFF);
        rd("mcycle_wr", 12'hB00, 64'hFFFF_FFFF);
        rd("mcycle_carry", 12'hB00, 64'h1_0000_0000);
        wr("minstret_w", 2'b01, 12'hB02, 64'h5);
        instr_retired = 1'b1;
        tick(); tick(); tick();
        instr_retired = 1'b0;
        rd("minstret", 12'hB02, 64'h8);
        rd("instret", 12'hC02, 64'h8);
`ifdef CSR_COUNTER_INHIBIT_EN
        wr("inhibit_w", 2'b01, 12'h320, 64'h7);
        rd("inhibit_rd", 12'h320, 64'h5);
        wr("mcycle_w100", 2'b01, 12'hB00, 64'd100);
        instr_retired = 1'b1;
        repeat (10) tick();
        instr_retired = 1'b0;
        rd("mcycle_frozen", 12'hB00, 64'd100);
        rd("time_frozen", 12'hC01, 64'd100);
        rd("minstret_frozen", 12'hB02, 64'h8);
`else
        ill("mcountinhibit_absent", 2'b00, 12'h320, 64'h0);
`endif

        // Reset during TRAP aborts the redirect
        exc_req = 1'b1; exc_cause = 4'd5; pc = 64'h5000;
        tick();
        exc_req = 1'b0; rst = 1'b1;
        #1;
        chk("rst_trap_redir_vld", 64'(redirect_valid), 64'd0);
        chk("rst_trap_redir_pc", redirect_pc, 64'h0);
        tick();
        rst = 1'b0;
        #1;
        chk("rst_trap_busy", 64'(busy), 64'd0);
        chk("rst_trap_priv", 64'(priv_lvl), 64'd3);
        tick();
        rd("rst_trap_mcause", 12'h342, 64'h0);
        rd("rst_trap_mepc", 12'h341, 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/csr_machine_trap.md
Name: csr_machine_trap

Overview:
- Parametrised successor to the fixed-width RV64 machine CSR file.
- Owns the machine CSRs, the hart privilege level and the trap entry/return sequencer.
- Arbitrates MEI/MSI/MTI interrupts against synchronous exceptions and MRET, then issues a one-cycle PC redirect to the fetch stage.
- Supports CSRRW/CSRRS/CSRRC read-modify-write with privilege and read-only legality checks.

Parameters:
- XLEN, 64, register width; 32 or 64 only.
- NUM_PMP, 4, number of pmpaddrN registers at 0x3B0+i; range 1..16.
- HART_ID, 0, constant value returned by mhartid.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- csr_valid  in  1  CSR instruction present this cycle
- csr_op  in  2  01 = RW, 10 = RS, 11 = RC; 00 = read-only, no write
- csr_addr  in  12  CSR address
- csr_wdata  in  XLEN  rs1 or zimm operand
- csr_rdata  out  XLEN  combinational old value; 0 when illegal
- csr_illegal  out  1  combinational illegal-access flag
- pc  in  XLEN  PC of the faulting instruction, or next PC for an interrupt
- instr_retired  in  1  one instruction retired this cycle
- exc_req  in  1  synchronous exception request
- exc_cause  in  4  exception code
- exc_tval  in  XLEN  trap value
- mret_req  in  1  MRET executing
- irq_ext, irq_soft, irq_timer  in  1 each  level interrupt lines
- priv_lvl  out  2  current privilege; 0 = U, 3 = M
- redirect_valid  out  1  one-cycle pulse
- redirect_pc  out  XLEN  redirect target
- busy  out  1  high in TRAP and RET states
- irq_pending  out  1  an interrupt is enabled and pending

Behaviour:
- Reset:
  - All CSRs 0 except misa.
  - misa MXL field = 2 at [63:62] for XLEN=64, or 1 at [31:30] for XLEN=32; bit 8 (I) set.
  - priv_lvl = 3, state = RUN, redirect_valid = 0, redirect_pc = 0, busy = 0.
  - Interrupt synchroniser flops cleared.
  - A reset during TRAP or RET aborts the sequence; no CSR update and no redirect.
- mip:
  - Bits 11/3/7 are irq_ext/irq_soft/irq_timer registered one cycle.
  - Writes to mip are ignored but legal.
- mie: only bits 11, 7 and 3 are writable.
- mstatus:
  - Writable fields are MIE[3], MPIE[7] and MPP[12:11].
  - A written MPP of 01 or 10 retains the old MPP (WARL).
- mtvec:
  - [1:0] = mode; values 00 and 01 are kept, 1x is written as 00.
  - mepc[1:0] always reads 0.
- CSR legality (csr_illegal=1): any of
  - unmapped address;
  - priv_lvl < csr_addr[9:8];
  - effective write to an address with [11:10] = 11.
- Effective write: op=RW; or op=RS/RC with csr_wdata != 0.
- Write value: RW = wdata; RS = old | wdata; RC = old & ~wdata.
- Write timing: the CSR is updated at the clock edge when csr_valid, !csr_illegal, state=RUN and no trap or MRET is accepted that cycle.
- Counters:
  - mcycle is 64 bits and increments every cycle; minstret is 64 bits and increments on instr_retired.
  - A CSR write in the same cycle overrides the increment.
  - time (0xC01) reads mcycle.
  - cycle (0xC00), time (0xC01) and instret (0xC02) are readable from U-mode.
  - XLEN=32: mcycleh 0xB80, minstreth 0xB82, cycleh 0xC80 and instreth 0xC82 return the upper halves. For XLEN=64 these addresses are illegal.
- Interrupt request:
  - irq_pending = |(mie & mip).
  - An interrupt is taken when irq_pending and (mstatus.MIE or priv_lvl < 3).
  - Priority MEI(11) > MSI(3) > MTI(7).
- Event priority in RUN: exc_req > mret_req > interrupt.
  - mret_req with priv_lvl != 3 becomes an exception with cause 2 and tval 0.
  - All requests are ignored while busy.
- FSM: RUN -> TRAP or RET on the accepted event; both return to RUN after 1 cycle.
  - pc, cause, tval and the interrupt flag are latched on acceptance.
- TRAP cycle:
  - mepc = pc_lat with [1:0] cleared.
  - mcause = {intr, zeros, cause}; mtval = tval_lat (0 for interrupts).
  - MPIE = MIE, MIE = 0, MPP = priv_lvl, priv_lvl = 3.
  - redirect_pc = base + 4*cause if mtvec.mode=01 and intr, else base, where base = mtvec with [1:0] cleared.
- RET cycle:
  - MIE = MPIE, MPIE = 1, priv_lvl = MPP, MPP = 0.
  - redirect_pc = mepc.
- Latency: event accepted in cycle N -> CSR updates and redirect_valid pulse in cycle N+1 -> RUN in N+2.

Optional Feature:
- CSR_COUNTER_INHIBIT_EN defined:
  - Adds mcountinhibit at 0x320, M-mode, writable bits CY[0] and IR[2].
  - A set bit freezes mcycle (and time) or minstret respectively; CSR writes to the counters still take effect.
- Undefined: 0x320 is unmapped and illegal; counters always run.

Test Plan:
- Reset, XLEN=64 -> read misa = 0x8000000000000100, priv_lvl = 3; RS 0x300 with wdata 0x8 -> mstatus = 0x8.
- Write mtvec = 0x1001, set mie[7] and MIE, raise irq_timer at pc = 0x2000 -> redirect_valid 2 cycles later with redirect_pc = 0x101C; mcause = 0x8000000000000007, mepc = 0x2000, MIE = 0, MPIE = 1.
- From the trap above, mret_req -> redirect_pc = 0x2000, MIE = 1, priv_lvl = 3; next cycle busy = 0.
- After MRET to U (MPP = 0), CSRRS 0x300 with wdata 0 -> csr_illegal = 1; read 0xC00 -> legal, returns the cycle count; write 0xC00 -> illegal.
- exc_req (cause 2, tval 0x300), mret_req and csr_valid RW 0x340 in the same cycle -> trap with mcause = 2, mscratch unchanged.
- XLEN=32: write mcycle = 0xFFFFFFFF -> next cycle read mcycleh = 1, mcycle = 0; with CSR_COUNTER_INHIBIT_EN, set mcountinhibit = 1 -> mcycle is constant over 10 cycles.
